// File: rtl/line_sched.sv
// Line command scheduler: queues endpoint commands and sequences them through
// an external line drawer, forwarding each drawn pixel to the framebuffer port.
module line_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_x0,
    input  logic [10:0] cmd_y0,
    input  logic [10:0] cmd_x1,
    input  logic [10:0] cmd_y1,
    input  logic        cmd_color,
    input  logic        flush,
    output logic        ld_reset,
    output logic [10:0] ld_x0,
    output logic [10:0] ld_y0,
    output logic [10:0] ld_x1,
    output logic [10:0] ld_y1,
    input  logic [10:0] ld_x,
    input  logic [10:0] ld_y,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        pixel_color,
    output logic        pixel_we,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] x1;
        logic [10:0] y1;
        logic        color;
    } cmd_t;

    cmd_t        mem_q [DEPTH];
    cmd_t        cmd_in;
    cmd_t        cur_q;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    state_t      state_q, state_d;
    logic [11:0] cnt_q;
    logic [11:0] len;
    logic [10:0] dx, dy, span;
    logic        empty, full, push, pop;

    assign cmd_in = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push   = cmd_valid && !full && !flush;

    // Pixel count is the major-axis span plus one, so a point line yields one pixel.
    assign dx   = (cur_q.x1 >= cur_q.x0) ? (cur_q.x1 - cur_q.x0) : (cur_q.x0 - cur_q.x1);
    assign dy   = (cur_q.y1 >= cur_q.y0) ? (cur_q.y1 - cur_q.y0) : (cur_q.y0 - cur_q.y1);
    assign span = (dx >= dy) ? dx : dy;
    assign len  = {1'b0, span} + 12'd1;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        ld_reset = 1'b0;
        pixel_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_reset = 1'b1;
                state_d  = DRAW;
            end
            DRAW: begin
                pixel_we = 1'b1;
                if (cnt_q == 12'd1) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            pop      = 1'b0;
            pixel_we = 1'b0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (flush) begin
                rd_ptr_q <= wr_ptr_q;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
                cur_q    <= mem_q[rd_ptr_q[AW-1:0]];
            end
            if (state_q == LOAD)      cnt_q <= len;
            else if (state_q == DRAW) cnt_q <= cnt_q - 12'd1;
        end
    end

    // Queue storage carries no reset; occupancy is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
    end

    assign cmd_ready   = !full;
    assign ld_x0       = cur_q.x0;
    assign ld_y0       = cur_q.y0;
    assign ld_x1       = cur_q.x1;
    assign ld_y1       = cur_q.y1;
    assign pixel_x     = ld_x;
    assign pixel_y     = ld_y;
    assign pixel_color = cur_q.color;
    assign busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_line_sched.sv
// Bench for line_sched: a Bresenham drawer model feeds ld_x/ld_y, and a
// write-list scoreboard built from accepted commands checks every framebuffer write.
module tb_line_sched;
    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, cmd_color, flush;
    logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic        ld_reset;
    logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1, ld_x, ld_y;
    logic [10:0] pixel_x, pixel_y;
    logic        pixel_color, pixel_we, busy;

    int checks = 0;
    int passed = 0;
    int wr_cnt = 0;
    int idx;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } pix_t;
    pix_t wq[$];

    line_sched #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .flush(flush), .ld_reset(ld_reset),
        .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
        .ld_x(ld_x), .ld_y(ld_y), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_color(pixel_color), .pixel_we(pixel_we), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int line_len(input int x0, input int y0, input int x1, input int y1);
        int a, b;
        a = iabs(x1 - x0);
        b = iabs(y1 - y0);
        return ((a > b) ? a : b) + 1;
    endfunction

    // i-th pixel of the classic integer Bresenham walk along the major axis
    function automatic logic [21:0] bres(input int x0, input int y0, input int x1,
                                         input int y1, input int i);
        int t, dx, dy, err, y, ys, k;
        bit steep;
        logic [10:0] px, py;
        steep = iabs(y1 - y0) > iabs(x1 - x0);
        if (steep) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dx  = x1 - x0;
        dy  = iabs(y1 - y0);
        err = -(dx / 2);
        y   = y0;
        ys  = (y0 < y1) ? 1 : -1;
        k   = (i > dx) ? dx : i;
        for (int j = 0; j < k; j++) begin
            err += dy;
            if (err >= 0) begin
                y   += ys;
                err -= dx;
            end
        end
        px = 11'(x0 + k);
        py = 11'(y);
        return steep ? {py, px} : {px, py};
    endfunction

    function automatic void add_cmd(input int x0, input int y0, input int x1,
                                    input int y1, input logic c);
        logic [21:0] r;
        pix_t p;
        for (int i = 0; i < line_len(x0, y0, x1, y1); i++) begin
            r   = bres(x0, y0, x1, y1, i);
            p.x = r[21:11];
            p.y = r[10:0];
            p.c = c;
            wq.push_back(p);
        end
    endfunction

    // Drawer model: restarts on ld_reset, advances one pixel per cycle
    always @(posedge clk) begin
        if (reset || ld_reset) idx <= 0;
        else if (idx < 4095)   idx <= idx + 1;
    end
    assign {ld_x, ld_y} = bres(int'(ld_x0), int'(ld_y0), int'(ld_x1), int'(ld_y1), idx);

    // Scoreboard monitor
    always @(negedge clk) begin
        pix_t p;
        if (reset) begin
            wq.delete();
        end else begin
            if (flush) begin
                checks++;
                if (pixel_we !== 1'b0) $display("FAIL flush_we: got %b need 0", pixel_we);
                else passed++;
                wq.delete();
            end else if (pixel_we === 1'b1) begin
                wr_cnt++;
                checks++;
                if (wq.size() == 0) begin
                    $display("FAIL unexpected_write: got (%0d,%0d) need none", pixel_x, pixel_y);
                end else begin
                    p = wq.pop_front();
                    if ({pixel_x, pixel_y, pixel_color} !== {p.x, p.y, p.c})
                        $display("FAIL pixel: got (%0d,%0d,c%0d) need (%0d,%0d,c%0d)",
                                 pixel_x, pixel_y, pixel_color, p.x, p.y, p.c);
                    else passed++;
                end
            end
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && flush !== 1'b1)
                add_cmd(int'(cmd_x0), int'(cmd_y0), int'(cmd_x1), int'(cmd_y1), cmd_color);
        end
    end

    task automatic push(input int x0, input int y0, input int x1, input int y1, input logic c);
        int n;
        n = 0;
        cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
        cmd_color = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (n >= 400) begin
            checks++;
            $display("FAIL push_timeout: got no accept need accept within 400 cycles");
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_color = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, pixel_we, ld_reset, busy} !== 4'b1000)
            $display("FAIL reset_ctrl: got rdy/we/ldr/busy=%b need 1000",
                     {cmd_ready, pixel_we, ld_reset, busy});
        else passed++;
        checks++;
        if ({ld_x0, ld_y0, ld_x1, ld_y1, pixel_color} !== 45'd0)
            $display("FAIL reset_cur: got %h need 0", {ld_x0, ld_y0, ld_x1, ld_y1, pixel_color});
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        push(0, 0, 3, 0, 1'b1);
        @(negedge clk);
        checks++;
        if ({ld_reset, busy} !== 2'b01) $display("FAIL single_pre: got ldr/busy=%b need 01", {ld_reset, busy});
        else passed++;
        @(negedge clk);
        checks++;
        if ({ld_reset, pixel_we} !== 2'b10) $display("FAIL single_load: got ldr/we=%b need 10", {ld_reset, pixel_we});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({pixel_we, pixel_x, pixel_y, pixel_color} !== {1'b1, 11'(i), 11'd0, 1'b1})
                $display("FAIL single_px%0d: got we%0d (%0d,%0d) need we1 (%0d,0)",
                         i, pixel_we, pixel_x, pixel_y, i);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if ({pixel_we, busy, ld_reset} !== 3'b000)
            $display("FAIL single_end: got we/busy/ldr=%b need 000", {pixel_we, busy, ld_reset});
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int ex[10] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 6};
        int ey[10] = '{0, 1, 2, 3, 4, 5, 3, 4, 5, 6};
        int px[16], py[16];
        int n, gap, ldr, cyc;
        n = 0; gap = 0; ldr = 0; cyc = 0;
        push(0, 0, 2, 5, 1'b1);
        push(6, 6, 3, 3, 1'b0);
        while (cyc < 60 && !(n > 0 && busy === 1'b0)) begin
            @(negedge clk);
            cyc++;
            if (pixel_we === 1'b1) begin
                if (n < 16) begin px[n] = pixel_x; py[n] = pixel_y; end
                n++;
            end else if (n == 6) begin
                gap++;
                if (ld_reset === 1'b1) ldr++;
            end
        end
        checks++;
        if (n != 10) $display("FAIL b2b_count: got %0d writes need 10", n);
        else passed++;
        checks++;
        if (gap != 1 || ldr != 1) $display("FAIL b2b_gap: got gap %0d load %0d need 1 1", gap, ldr);
        else passed++;
        for (int i = 0; i < 10 && i < n; i++) begin
            checks++;
            if (px[i] != ex[i] || py[i] != ey[i])
                $display("FAIL b2b_px%0d: got (%0d,%0d) need (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int c[4][5];
        int base, total, x0, y0, x1, y1;
        bit ok;
        logic col;
        base  = wr_cnt;
        total = 101;
        push(0, 0, 100, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) c[k][j] = $urandom_range(0, 7);
            c[k][4] = $urandom_range(0, 1);
            total += line_len(c[k][0], c[k][1], c[k][2], c[k][3]);
            push(c[k][0], c[k][1], c[k][2], c[k][3], c[k][4][0]);
        end
        x0 = $urandom_range(0, 9); y0 = $urandom_range(0, 9);
        x1 = $urandom_range(0, 9); y1 = $urandom_range(0, 9);
        col = 1'($urandom_range(0, 1));
        total += line_len(x0, y0, x1, y1);
        cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
        cmd_color = col; cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) $display("FAIL bp_full%0d: got ready %b need 0", k, cmd_ready);
            else passed++;
            @(posedge clk); #1;
        end
        push(x0, y0, x1, y1, col);
        checks++;
        if (wr_cnt - base != 101)
            $display("FAIL bp_accept_time: got %0d long-line writes before accept need 101", wr_cnt - base);
        else passed++;
        wait_idle(ok);
        checks++;
        if (!ok || wq.size() != 0 || wr_cnt - base != total)
            $display("FAIL bp_drain: got idle %0d left %0d writes %0d need 1 0 %0d",
                     ok, wq.size(), wr_cnt - base, total);
        else passed++;
    endtask

    task automatic test_point();
        int base;
        bit ok;
        base = wr_cnt;
        push(5, 5, 5, 5, 1'($urandom_range(0, 1)));
        wait_idle(ok);
        checks++;
        if (!ok || wr_cnt - base != 1 || wq.size() != 0)
            $display("FAIL point: got idle %0d writes %0d left %0d need 1 1 0", ok, wr_cnt - base, wq.size());
        else passed++;
    endtask

    task automatic test_flush();
        int base, cnt, n, stray;
        base = wr_cnt; cnt = 0; n = 0; stray = 0;
        push(0, 0, 10, 0, 1'b1);
        push(1, 1, 4, 4, 1'b0);
        push(2, 2, 2, 9, 1'b1);
        while (cnt < 2 && n < 50) begin
            @(negedge clk);
            if (pixel_we === 1'b1) cnt++;
            n++;
        end
        checks++;
        if (cnt != 2) $display("FAIL flush_pre: got %0d writes need 2", cnt);
        else passed++;
        @(posedge clk); #1;
        flush = 1'b1;
        cmd_x0 = 11'd7; cmd_y0 = 11'd7; cmd_x1 = 11'd9; cmd_y1 = 11'd9; cmd_color = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (pixel_we !== 1'b0) $display("FAIL flush_cycle_we: got %b need 0", pixel_we);
        else passed++;
        @(posedge clk); #1;
        flush = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, pixel_we, ld_reset} !== 3'b000)
            $display("FAIL flush_idle: got busy/we/ldr=%b need 000", {busy, pixel_we, ld_reset});
        else passed++;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || pixel_we !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || wr_cnt - base != 2)
            $display("FAIL flush_after: got stray %0d writes %0d need 0 2", stray, wr_cnt - base);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int base, cnt, n, stray;
        base = wr_cnt; cnt = 0; n = 0; stray = 0;
        push(0, 0, 20, 3, 1'b1);
        push(3, 3, 8, 8, 1'b1);
        while (cnt < 3 && n < 50) begin
            @(negedge clk);
            if (pixel_we === 1'b1) cnt++;
            n++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pixel_we, cmd_ready, busy, ld_reset} !== 4'b0100)
            $display("FAIL rstmid_ctrl: got we/rdy/busy/ldr=%b need 0100",
                     {pixel_we, cmd_ready, busy, ld_reset});
        else passed++;
        checks++;
        if ({ld_x0, ld_y0, ld_x1, ld_y1, pixel_color} !== 45'd0)
            $display("FAIL rstmid_cur: got %h need 0", {ld_x0, ld_y0, ld_x1, ld_y1, pixel_color});
        else passed++;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || pixel_we !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || wr_cnt - base != 3)
            $display("FAIL rstmid_after: got stray %0d writes %0d need 0 3", stray, wr_cnt - base);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int base, total, x0, y0, x1, y1;
        bit ok;
        base = wr_cnt; total = 0;
        for (int k = 0; k < 10; k++) begin
            x0 = $urandom_range(0, 15); y0 = $urandom_range(0, 15);
            x1 = $urandom_range(0, 15); y1 = $urandom_range(0, 15);
            total += line_len(x0, y0, x1, y1);
            push(x0, y0, x1, y1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || wq.size() != 0 || wr_cnt - base != total)
            $display("FAIL random_drain: got idle %0d left %0d writes %0d need 1 0 %0d",
                     ok, wq.size(), wr_cnt - base, total);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_point();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/line_sched.md
LINE_SCHED -- requirements
Module: line_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the command FIFO depth in entries (power of 2, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: the line command on cmd_* is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: a command is accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-006 SHALL have ports cmd_x0, cmd_y0, cmd_x1, cmd_y1, input, 11 bits each: the line endpoints.
REQ-007 SHALL have port cmd_color, input, 1 bit: the pixel value for the line (1 = draw, 0 = erase).
REQ-008 SHALL have port flush, input, 1 bit: abort the current line and discard all queued commands.
REQ-009 SHALL have port ld_reset, output, 1 bit: the start pulse to the line drawer.
REQ-010 SHALL have ports ld_x0, ld_y0, ld_x1, ld_y1, output, 11 bits each: endpoints to the drawer.
REQ-011 SHALL have ports ld_x, ld_y, input, 11 bits each: the current pixel from the drawer.
REQ-012 SHALL have ports pixel_x, pixel_y (output, 11 bits each), pixel_color (output, 1 bit) and pixel_we (output, 1 bit): the framebuffer write port.
REQ-013 SHALL have port busy, output, 1 bit: high when a line is in progress or the FIFO is non-empty.

Function
REQ-014 SHALL queue accepted commands (x0, y0, x1, y1, color) in a DEPTH-entry FIFO, in order.
REQ-015 SHALL drive cmd_ready = !full, so a push is never accepted when the FIFO is full, including a full FIFO with a pop in the same cycle.
REQ-016 SHALL, on an accept and a pop in the same cycle, leave the occupancy unchanged.
REQ-017 SHALL implement FSM states IDLE, LOAD and DRAW.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head into the current-line registers (cur_*) and go to LOAD.
REQ-019 SHALL, in IDLE with the FIFO empty, stay in IDLE.
REQ-020 SHALL, in LOAD, drive ld_reset=1 for exactly one cycle, load the pixel counter with len = max(|x1-x0|, |y1-y0|) + 1 (12-bit unsigned), and go to DRAW.
REQ-021 SHALL drive ld_x0..ld_y1 from cur_* at all times; cur_* change only on a pop, so endpoints are stable from LOAD through the last DRAW cycle.
REQ-022 SHALL, in DRAW, drive pixel_we=1, pixel_x=ld_x, pixel_y=ld_y and pixel_color=cur_color, and decrement the counter each cycle.
REQ-023 SHALL, in DRAW when the counter equals 1 (the last pixel), pop the next command and go to LOAD if the FIFO is non-empty, else go to IDLE.
REQ-024 SHALL produce exactly len pixel_we cycles per line: the first in the cycle after LOAD, contiguous, with no duplicate and no missing pixel.
REQ-025 SHALL, for a point line (x0=x1, y0=y1), produce len=1 and exactly one write.
REQ-026 SHALL impose back-to-back overhead of exactly 1 LOAD cycle between lines when the FIFO is non-empty.
REQ-027 SHALL hold pixel_we=0 and ld_reset=0 in IDLE.
REQ-028 SHALL, on flush (any state), empty the FIFO, go to IDLE next cycle and drive pixel_we=0 in the flush cycle.
REQ-029 SHALL give flush priority over a simultaneous cmd accept, so the command is dropped.
REQ-030 SHALL compute busy = (state != IDLE) | !empty.

Reset
REQ-031 SHALL, on reset, set the state to IDLE and empty the FIFO.
REQ-032 SHALL, on reset, drive cmd_ready=1, pixel_we=0, ld_reset=0 and busy=0.
REQ-033 SHALL, on reset, set cur_* and pixel_color to 0.
REQ-034 SHALL, on reset mid-line, abandon the line with no further writes.
REQ-035 SHALL give reset priority over flush and cmd accept.

Verification
REQ-036 SHALL cover: one command (0,0)->(3,0), color 1 -> LOAD one cycle later; then 4 writes at x=0,1,2,3, y=0; then IDLE, busy=0.
REQ-037 SHALL cover: two commands pushed back-to-back, (0,0)->(2,5) and (6,6)->(3,3) -> 6 writes (0,0),(1,1),(1,2),(1,3),(2,4),(2,5); exactly one LOAD cycle; then 4 writes (3,3)..(6,6).
REQ-038 SHALL cover: 5 commands pushed while a long line (0,0)->(100,0) draws, DEPTH=4 -> cmd_ready low after 4 are queued; the 5th is accepted only after a pop; all 5 lines are drawn in order.
REQ-039 SHALL cover: a point line (5,5)->(5,5) -> exactly one write at (5,5).
REQ-040 SHALL cover: flush on the 3rd pixel of (0,0)->(10,0) with 2 queued -> writes stop that cycle; IDLE; busy=0 next cycle; no queued line drawn.
REQ-041 SHALL cover: reset asserted mid-DRAW -> pixel_we=0 the following cycle; cmd_ready=1; state IDLE.
